// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the multiplier datapath: operand class
// encoding, field widths and the canonical quiet-NaN pattern.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  // Result / operand class, matches the res_class output encoding.
  typedef enum logic [1:0] {
    FP_FINITE = 2'b00,
    FP_ZERO   = 2'b01,
    FP_INF    = 2'b10,
    FP_NAN    = 2'b11
  } fp_class_e;

  // One pipeline slot: the valid bit travels alongside the resolved result.
  typedef struct packed {
    logic      valid;
    logic      sign;
    fp_class_e cls;
    logic      invalid;
  } sign_stage_t;

endpackage

// File: rtl/sign_calculation_if.sv
// Operand/result bundle between the multiplier front end, the sign stage
// and the final packer. master drives operands, slave returns the result.
interface sign_calculation_if;

  logic        in_valid;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        sign_out;
  logic [1:0]  res_class;
  logic        invalid;

  modport master (
    output in_valid, x, y,
    input  out_valid, sign_out, res_class, invalid
  );

  modport slave (
    input  in_valid, x, y,
    output out_valid, sign_out, res_class, invalid
  );

endinterface

// File: rtl/fp32_classify.sv
// Combinational classification of a single binary32 operand (sign bit not
// needed) into finite / zero / inf / NaN, plus a signalling-NaN flag.
module fp32_classify
  import fp32_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic [EXP_W-1:0] exp_f,
  input  logic [MAN_W-1:0] man_f,
  output fp_class_e        op_class,
  output logic             snan
);

  // Decode exponent/mantissa; subnormals collapse to zero when flushing.
  always_comb begin
    op_class = FP_FINITE;
    snan     = 1'b0;
    if (exp_f == EXP_MAX) begin
      if (man_f != '0) begin
        op_class = FP_NAN;
        // Quiet bit clear on a NaN marks it as signalling.
        snan     = ~man_f[MAN_W-1];
      end else begin
        op_class = FP_INF;
      end
    end else if (exp_f == '0) begin
      if ((man_f == '0) || FTZ) begin
        op_class = FP_ZERO;
      end
    end
  end

endmodule

// File: rtl/sign_calculation.sv
// Sign and special-case resolution for the FP32 multiplier. Both operands
// are classified combinationally, the product class/sign/invalid flag is
// resolved in priority order, and the result is delayed LATENCY cycles so
// it lines up with the mantissa and exponent paths.
module sign_calculation
  import fp32_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter bit FTZ     = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  sign_calculation_if.slave  bus
);

  // Legal depth is 1..4; anything outside is clamped so the chain is never empty.
  localparam int DEPTH = (LATENCY < 1) ? 1 : ((LATENCY > 4) ? 4 : LATENCY);

  fp_class_e   cls_x;
  fp_class_e   cls_y;
  logic        snan_x;
  logic        snan_y;
  logic        prod_sign;
  logic        inf_times_zero;
  sign_stage_t stage_next;

  fp32_classify #(.FTZ(FTZ)) u_classify_x (
    .exp_f    (bus.x[30:23]),
    .man_f    (bus.x[22:0]),
    .op_class (cls_x),
    .snan     (snan_x)
  );

  fp32_classify #(.FTZ(FTZ)) u_classify_y (
    .exp_f    (bus.y[30:23]),
    .man_f    (bus.y[22:0]),
    .op_class (cls_y),
    .snan     (snan_y)
  );

  assign prod_sign      = bus.x[31] ^ bus.y[31];
  assign inf_times_zero = ((cls_x == FP_INF) && (cls_y == FP_ZERO)) ||
                          ((cls_x == FP_ZERO) && (cls_y == FP_INF));

  // Resolve the product class in priority order: NaN in, inf*0, inf, zero, finite.
  always_comb begin
    stage_next.valid   = bus.in_valid;
    stage_next.sign    = prod_sign;
    stage_next.cls     = FP_FINITE;
    stage_next.invalid = 1'b0;
    if ((cls_x == FP_NAN) || (cls_y == FP_NAN)) begin
      // NaN results carry the canonical qNaN sign so the packer emits 7FC00000.
      stage_next.cls     = FP_NAN;
      stage_next.sign    = QNAN[31];
      stage_next.invalid = snan_x | snan_y;
    end else if (inf_times_zero) begin
      stage_next.cls     = FP_NAN;
      stage_next.sign    = QNAN[31];
      stage_next.invalid = 1'b1;
    end else if ((cls_x == FP_INF) || (cls_y == FP_INF)) begin
      stage_next.cls     = FP_INF;
    end else if ((cls_x == FP_ZERO) || (cls_y == FP_ZERO)) begin
      // Signed zero is kept: -0 * finite yields -0.
      stage_next.cls     = FP_ZERO;
    end
  end

  // Delay line: every stage loads unconditionally, valid rides with the data.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      sign_stage_t d_in;
      sign_stage_t stage_reg;

      if (gi == 0) begin : g_head
        assign d_in = stage_next;
      end else begin : g_tail
        assign d_in = g_stage[gi-1].stage_reg;
      end

      // Stage register; asynchronous reset discards whatever is in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= d_in;
        end
      end
    end
  endgenerate

  assign bus.out_valid = g_stage[DEPTH-1].stage_reg.valid;
  assign bus.sign_out  = g_stage[DEPTH-1].stage_reg.sign;
  assign bus.res_class = g_stage[DEPTH-1].stage_reg.cls;
  assign bus.invalid   = g_stage[DEPTH-1].stage_reg.invalid;

endmodule

// File: tb/tb_sign_calculation.sv
// Bench for sign_calculation: three instances (LATENCY 1 with FTZ 1 and 0,
// LATENCY 3 with FTZ 1) share one operand stream and are compared every
// cycle against a rule-level reference model and a history queue.
module tb_sign_calculation;
  import fp32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] x;
  logic [31:0] y;

  always #5 clk = ~clk;

  sign_calculation_if bus_l1f1 ();
  sign_calculation_if bus_l1f0 ();
  sign_calculation_if bus_l3f1 ();

  assign bus_l1f1.in_valid = in_valid;
  assign bus_l1f1.x        = x;
  assign bus_l1f1.y        = y;
  assign bus_l1f0.in_valid = in_valid;
  assign bus_l1f0.x        = x;
  assign bus_l1f0.y        = y;
  assign bus_l3f1.in_valid = in_valid;
  assign bus_l3f1.x        = x;
  assign bus_l3f1.y        = y;

  sign_calculation #(.LATENCY(1), .FTZ(1'b1)) dut_l1f1 (.clk(clk), .rst_n(rst_n), .bus(bus_l1f1));
  sign_calculation #(.LATENCY(1), .FTZ(1'b0)) dut_l1f0 (.clk(clk), .rst_n(rst_n), .bus(bus_l1f0));
  sign_calculation #(.LATENCY(3), .FTZ(1'b1)) dut_l3f1 (.clk(clk), .rst_n(rst_n), .bus(bus_l3f1));

  typedef struct {
    logic       v;
    logic       s;
    logic [1:0] c;
    logic       inv;
  } exp_t;

  exp_t hist_f1[$];
  exp_t hist_f0[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  // Operand kind from the binary32 rules: 0 finite, 1 zero, 2 inf, 3 qNaN, 4 sNaN.
  function automatic int kind(logic [31:0] f, bit ftz);
    logic [7:0]  e;
    logic [22:0] m;
    e = f[30:23];
    m = f[22:0];
    if (e == 8'hFF) begin
      if (m == 23'd0) return 2;
      return m[22] ? 3 : 4;
    end
    if ((e == 8'h00) && ((m == 23'd0) || ftz)) return 1;
    return 0;
  endfunction

  function automatic exp_t ref_model(logic v, logic [31:0] a, logic [31:0] b, bit ftz);
    exp_t r;
    int   ka;
    int   kb;
    ka    = kind(a, ftz);
    kb    = kind(b, ftz);
    r.v   = v;
    r.s   = a[31] ^ b[31];
    r.inv = 1'b0;
    if (ka >= 3 || kb >= 3) begin
      r.c = 2'b11; r.s = 1'b0; r.inv = (ka == 4) || (kb == 4);
    end else if ((ka == 2 && kb == 1) || (ka == 1 && kb == 2)) begin
      r.c = 2'b11; r.s = 1'b0; r.inv = 1'b1;
    end else if (ka == 2 || kb == 2) begin
      r.c = 2'b10;
    end else if (ka == 1 || kb == 1) begin
      r.c = 2'b01;
    end else begin
      r.c = 2'b00;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 6);
    case (k)
      0: rand_op = r;
      1: rand_op = {r[31], 31'd0};
      2: rand_op = {r[31], 8'hFF, 23'd0};
      3: rand_op = {r[31], 8'hFF, 1'b1, r[21:0]};
      4: rand_op = {r[31], 8'hFF, 1'b0, (r[21:0] == 22'd0) ? 22'd1 : r[21:0]};
      5: rand_op = {r[31], 8'h00, r[22:0] | 23'd1};
      default: rand_op = {r[31], r[0] ? 8'hFE : 8'h01, r[22:0]};
    endcase
  endfunction

  task automatic reset_model();
    exp_t z;
    z = '{1'b0, 1'b0, 2'b00, 1'b0};
    hist_f1 = {};
    hist_f0 = {};
    for (int i = 0; i < 4; i++) begin
      hist_f1.push_back(z);
      hist_f0.push_back(z);
    end
  endtask

  task automatic push_model(logic v, logic [31:0] a, logic [31:0] b);
    hist_f1.push_front(ref_model(v, a, b, 1'b1));
    void'(hist_f1.pop_back());
    hist_f0.push_front(ref_model(v, a, b, 1'b0));
    void'(hist_f0.pop_back());
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    exp_t e;
    e = hist_f1[0];
    chk({tag, " l1f1.out_valid"}, 32'(bus_l1f1.out_valid), 32'(e.v));
    chk({tag, " l1f1.sign_out"},  32'(bus_l1f1.sign_out),  32'(e.s));
    chk({tag, " l1f1.res_class"}, 32'(bus_l1f1.res_class), 32'(e.c));
    chk({tag, " l1f1.invalid"},   32'(bus_l1f1.invalid),   32'(e.inv));
    e = hist_f0[0];
    chk({tag, " l1f0.out_valid"}, 32'(bus_l1f0.out_valid), 32'(e.v));
    chk({tag, " l1f0.sign_out"},  32'(bus_l1f0.sign_out),  32'(e.s));
    chk({tag, " l1f0.res_class"}, 32'(bus_l1f0.res_class), 32'(e.c));
    chk({tag, " l1f0.invalid"},   32'(bus_l1f0.invalid),   32'(e.inv));
    e = hist_f1[2];
    chk({tag, " l3f1.out_valid"}, 32'(bus_l3f1.out_valid), 32'(e.v));
    chk({tag, " l3f1.sign_out"},  32'(bus_l3f1.sign_out),  32'(e.s));
    chk({tag, " l3f1.res_class"}, 32'(bus_l3f1.res_class), 32'(e.c));
    chk({tag, " l3f1.invalid"},   32'(bus_l3f1.invalid),   32'(e.inv));
  endtask

  // Spec-table constants for the LATENCY=1 instances, independent of the model.
  task automatic chk_l1(string tag, logic s, logic [1:0] c_f1, logic [1:0] c_f0, logic inv);
    chk({tag, " const l1f1.out_valid"}, 32'(bus_l1f1.out_valid), 32'd1);
    chk({tag, " const l1f1.sign_out"},  32'(bus_l1f1.sign_out),  32'(s));
    chk({tag, " const l1f1.res_class"}, 32'(bus_l1f1.res_class), 32'(c_f1));
    chk({tag, " const l1f1.invalid"},   32'(bus_l1f1.invalid),   32'(inv));
    chk({tag, " const l1f0.res_class"}, 32'(bus_l1f0.res_class), 32'(c_f0));
  endtask

  // One clock: drive operands, let the edge capture them, check just after.
  task automatic step(logic v, logic [31:0] a, logic [31:0] b);
    string tag;
    in_valid = v;
    x        = a;
    y        = b;
    @(posedge clk);
    push_model(v, a, b);
    #1;
    step_no++;
    tag = $sformatf("step%0d", step_no);
    check_all(tag);
    $display("%s v=%b x=%h y=%h l1f1:%b/%b/%b/%b l1f0:%b/%b/%b/%b l3f1:%b/%b/%b/%b",
             tag, v, a, b,
             bus_l1f1.out_valid, bus_l1f1.sign_out, bus_l1f1.res_class, bus_l1f1.invalid,
             bus_l1f0.out_valid, bus_l1f0.sign_out, bus_l1f0.res_class, bus_l1f0.invalid,
             bus_l3f1.out_valid, bus_l3f1.sign_out, bus_l3f1.res_class, bus_l3f1.invalid);
  endtask

  // Same as step, but rst_n pulses low mid-cycle before the edge captures the operands.
  task automatic step_with_reset(logic v, logic [31:0] a, logic [31:0] b);
    in_valid = v;
    x        = a;
    y        = b;
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    check_all("async_reset");
    chk("async_reset l3f1.out_valid low", 32'(bus_l3f1.out_valid), 32'd0);
    $display("async reset asserted mid-cycle at %0t", $time);
    #1;
    rst_n = 1'b1;
    step(v, a, b);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x        = 32'd0;
    y        = 32'd0;
    reset_model();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases from the operand rules.
    step(1'b1, 32'hBE99999A, 32'h43FA2000); chk_l1("neg_finite", 1'b1, 2'b00, 2'b00, 1'b0);
    step(1'b1, 32'h80000000, 32'h3F800000); chk_l1("neg_zero",   1'b1, 2'b01, 2'b01, 1'b0);
    step(1'b1, 32'h00000000, 32'h3F800000); chk_l1("pos_zero",   1'b0, 2'b01, 2'b01, 1'b0);
    step(1'b1, 32'hFF800000, 32'h00000000); chk_l1("inf_x_zero", 1'b0, 2'b11, 2'b11, 1'b1);
    step(1'b1, 32'hFF800000, 32'hBF800000); chk_l1("inf_x_neg1", 1'b0, 2'b10, 2'b10, 1'b0);
    step(1'b1, 32'h7FA00000, 32'h3F800000); chk_l1("snan",       1'b0, 2'b11, 2'b11, 1'b1);
    step(1'b1, 32'hFFC00000, 32'h3F800000); chk_l1("qnan",       1'b0, 2'b11, 2'b11, 1'b0);
    step(1'b1, 32'h00000001, 32'hBF800000); chk_l1("subnormal",  1'b1, 2'b01, 2'b00, 1'b0);
    step(1'b1, 32'h00000000, 32'h7F800000); chk_l1("zero_x_inf", 1'b0, 2'b11, 2'b11, 1'b1);
    step(1'b0, 32'h7F7FFFFF, 32'h80800000);
    step(1'b0, 32'h00000000, 32'h00000000);

    // Back-to-back stream into the LATENCY=3 instance with a reset in cycle 3.
    step(1'b1, 32'h3F800000, 32'hC0000000);
    step(1'b1, 32'h7F800000, 32'h7F800000);
    step_with_reset(1'b1, 32'hBF800000, 32'hBF800000);
    chk("post_reset l3f1.out_valid c1", 32'(bus_l3f1.out_valid), 32'd0);
    step(1'b1, 32'h80000000, 32'hFF800000);
    chk("post_reset l3f1.out_valid c2", 32'(bus_l3f1.out_valid), 32'd0);
    step(1'b1, 32'h7FC00000, 32'h00000001);
    chk("post_reset l3f1.out_valid c3", 32'(bus_l3f1.out_valid), 32'd1);
    chk("post_reset l3f1.res_class c3", 32'(bus_l3f1.res_class), 32'd0);
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);

    // Randomised stream with occasional mid-cycle resets.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        step_with_reset(1'($urandom_range(0, 1)), rand_op(), rand_op());
      end else begin
        step(1'($urandom_range(0, 3) != 0), rand_op(), rand_op());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
